// File: rtl/ms5803_i2c_slave.sv
// MS5803 pressure-sensor I2C target: ACKs DEV_ADDR, hands write bytes to
// the fabric as cmd/cmd_vld and shifts a 24-bit tx_data result out on reads.
// Ports: clk, rst_n (async, active low), scl, sda (open drain),
//        tx_data (read result), cmd/cmd_vld (write byte), rd_start, busy.
module ms5803_i2c_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h76
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    inout  wire         sda,
    input  logic [23:0] tx_data,
    output logic [7:0]  cmd,
    output logic        cmd_vld,
    output logic        rd_start,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX, TX_ACK, WAIT_STOP
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  scl_sync, sda_sync;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  rx_sr, rx_nxt;
    logic [23:0] tx_sr, tx_nxt;
    logic        sda_oe, oe_nxt;
    logic [7:0]  cmd_nxt;
    logic        cmd_vld_nxt, rd_start_nxt;

    logic scl_h, scl_q, sda_h, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_h     = scl_sync[1];
    assign scl_q     = scl_sync[2];
    assign sda_h     = sda_sync[1];
    assign sda_q     = sda_sync[2];
    assign scl_rise  = scl_h & ~scl_q;
    assign scl_fall  = ~scl_h & scl_q;
    assign start_det = scl_h & scl_q & sda_q & ~sda_h;
    assign stop_det  = scl_h & scl_q & ~sda_q & sda_h;
    assign rx_byte   = {rx_sr[6:0], sda_h};

    assign sda  = sda_oe ? 1'b0 : 1'bz;
    assign busy = (state != IDLE);

    // Synchronizers reset to the idle-bus level so release of reset
    // cannot fabricate a bus edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl};
            sda_sync <= {sda_sync[1:0], sda};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            rx_sr    <= 8'h00;
            tx_sr    <= 24'h0;
            sda_oe   <= 1'b0;
            cmd      <= 8'h00;
            cmd_vld  <= 1'b0;
            rd_start <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            rx_sr    <= rx_nxt;
            tx_sr    <= tx_nxt;
            sda_oe   <= oe_nxt;
            cmd      <= cmd_nxt;
            cmd_vld  <= cmd_vld_nxt;
            rd_start <= rd_start_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        rx_nxt       = rx_sr;
        tx_nxt       = tx_sr;
        oe_nxt       = sda_oe;
        cmd_nxt      = cmd;
        cmd_vld_nxt  = 1'b0;
        rd_start_nxt = 1'b0;
        if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = 3'd0;
            rx_nxt      = 8'h00;
            oe_nxt      = 1'b0;
        end else if (stop_det) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = 3'd0;
            oe_nxt      = 1'b0;
        end else begin
            unique case (state)
                ADDR, CMD: begin
                    if (scl_rise) begin
                        rx_nxt      = rx_byte;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == CMD) begin
                                cmd_nxt     = rx_byte;
                                cmd_vld_nxt = 1'b1;
                                state_nxt   = CMD_ACK;
                            end else if (rx_byte[7:1] != DEV_ADDR) begin
                                state_nxt = WAIT_STOP;
                            end else begin
                                state_nxt = ADDR_ACK;
                                if (rx_byte[0]) begin
                                    tx_nxt       = tx_data;
                                    rd_start_nxt = 1'b1;
                                end
                            end
                        end
                    end
                end
                // First fall drives the ACK, second fall ends the ACK slot;
                // rx_sr[0] still holds the R/W bit in ADDR_ACK.
                ADDR_ACK, CMD_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            oe_nxt = 1'b1;
                        end else begin
                            bit_cnt_nxt = 3'd0;
                            if (state == ADDR_ACK && rx_sr[0]) begin
                                state_nxt = TX;
                                oe_nxt    = ~tx_sr[23];
                            end else begin
                                state_nxt = CMD;
                                oe_nxt    = 1'b0;
                            end
                        end
                    end
                end
                // Ones are shifted in so reads past the third byte give FF.
                TX: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end else if (scl_fall) begin
                        tx_nxt = {tx_sr[22:0], 1'b1};
                        if (bit_cnt == 3'd0) begin
                            oe_nxt    = 1'b0;
                            state_nxt = TX_ACK;
                        end else begin
                            oe_nxt = ~tx_sr[22];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise && sda_h) begin
                        state_nxt = WAIT_STOP;
                    end else if (scl_fall) begin
                        state_nxt   = TX;
                        bit_cnt_nxt = 3'd0;
                        oe_nxt      = ~tx_sr[23];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ms5803_i2c_slave.sv
// Directed testbench for ms5803_i2c_slave: a bit-banged I2C master drives
// writes, reads, wrong address, repeated START, over-read and reset cases.
module tb_ms5803_i2c_slave;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    logic [23:0] tx_data = 24'h0;
    logic [7:0]  cmd;
    logic        cmd_vld;
    logic        rd_start;
    logic        busy;
    wire         sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    int checks = 0;
    int errors = 0;
    int n_vld = 0;
    int n_rd = 0;
    int n_slow = 0;
    int n_idle = 0;

    always #5 clk = ~clk;

    ms5803_i2c_slave dut (
        .clk(clk),
        .rst_n(rst_n),
        .scl(scl),
        .sda(sda),
        .tx_data(tx_data),
        .cmd(cmd),
        .cmd_vld(cmd_vld),
        .rd_start(rd_start),
        .busy(busy)
    );

    always @(negedge clk) begin
        if (cmd_vld) n_vld++;
        if (rd_start) n_rd++;
        if (!m_low && sda === 1'b0) n_slow++;
        if (!busy) n_idle++;
    end

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        m_low = 1'b0;
        wt(Q);
        scl = 1'b1;
        wt(Q);
        m_low = 1'b1;
        wt(Q);
        scl = 1'b0;
        wt(Q);
    endtask

    task automatic i2c_stop;
        wt(2);
        m_low = 1'b1;
        wt(Q - 2);
        scl = 1'b1;
        wt(Q);
        m_low = 1'b0;
        wt(Q);
    endtask

    task automatic put_bit(input logic b);
        wt(2);
        m_low = ~b;
        wt(Q - 2);
        scl = 1'b1;
        wt(Q);
        scl = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        wt(2);
        m_low = 1'b0;
        wt(Q - 2);
        scl = 1'b1;
        wt(Q / 2);
        b = sda;
        wt(Q / 2);
        scl = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic nack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(nack);
    endtask

    task automatic get_byte(input logic ack, output logic [7:0] d,
                            output logic oe);
        logic b;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        wt(2);
        m_low = ack;
        wt(Q - 2);
        scl = 1'b1;
        wt(Q / 2);
        oe = dut.sda_oe;
        wt(Q / 2);
        scl = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wt(5);
        checks++;
        if (cmd !== 8'h00) begin
            errors++;
            $display("FAIL reset_cmd: got %h expected 00", cmd);
        end
        checks++;
        if (cmd_vld !== 1'b0 || rd_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b%b expected 00", cmd_vld, rd_start);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (sda !== 1'b1) begin
            errors++;
            $display("FAIL reset_sda: got %b expected 1", sda);
        end
        rst_n = 1'b1;
        wt(5);
    endtask

    task automatic test_write;
        logic a;
        int v0;
        v0 = n_vld;
        i2c_start;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy: got %b expected 1", busy);
        end
        put_byte(8'hEC, a);
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL wr_addr_ack: got %b expected 0", a);
        end
        put_byte(8'h48, a);
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL wr_cmd_ack: got %b expected 0", a);
        end
        i2c_stop;
        checks++;
        if (cmd !== 8'h48) begin
            errors++;
            $display("FAIL wr_cmd: got %h expected 48", cmd);
        end
        checks++;
        if (n_vld - v0 !== 1) begin
            errors++;
            $display("FAIL wr_vld_cnt: got %0d expected 1", n_vld - v0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_read;
        logic a, oe;
        logic [7:0] d;
        logic [7:0] exp_b [3];
        int r0;
        exp_b = '{8'hA5, 8'h3C, 8'h81};
        tx_data = 24'hA5_3C_81;
        r0 = n_rd;
        i2c_start;
        put_byte(8'hED, a);
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL rd_addr_ack: got %b expected 0", a);
        end
        for (int i = 0; i < 3; i++) begin
            get_byte(i < 2, d, oe);
            checks++;
            if (d !== exp_b[i]) begin
                errors++;
                $display("FAIL rd_byte%0d: got %h expected %h", i, d, exp_b[i]);
            end
            checks++;
            if (oe !== 1'b0) begin
                errors++;
                $display("FAIL rd_ackslot%0d: got oe %b expected 0", i, oe);
            end
        end
        i2c_stop;
        checks++;
        if (n_rd - r0 !== 1) begin
            errors++;
            $display("FAIL rd_start_cnt: got %0d expected 1", n_rd - r0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_wrong_addr;
        logic a;
        int v0, r0, s0;
        v0 = n_vld;
        r0 = n_rd;
        s0 = n_slow;
        i2c_start;
        put_byte(8'hEE, a);
        checks++;
        if (a !== 1'b1) begin
            errors++;
            $display("FAIL wa_addr_nack: got %b expected 1", a);
        end
        put_byte(8'h12, a);
        checks++;
        if (a !== 1'b1) begin
            errors++;
            $display("FAIL wa_data_nack: got %b expected 1", a);
        end
        i2c_stop;
        checks++;
        if (n_slow !== s0) begin
            errors++;
            $display("FAIL wa_sda_low: got %0d low cycles expected 0", n_slow - s0);
        end
        checks++;
        if (n_vld !== v0 || n_rd !== r0) begin
            errors++;
            $display("FAIL wa_pulses: got %0d/%0d expected 0/0", n_vld - v0, n_rd - r0);
        end
    endtask

    task automatic test_repeated_start;
        logic a, oe;
        logic [7:0] d;
        logic [7:0] exp_b [3];
        int v0, i0;
        exp_b = '{8'h5A, 8'h0F, 8'hC3};
        tx_data = 24'h5A_0F_C3;
        v0 = n_vld;
        i2c_start;
        put_byte(8'hEC, a);
        put_byte(8'h00, a);
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL rs_cmd_ack: got %b expected 0", a);
        end
        i0 = n_idle;
        i2c_start;
        put_byte(8'hED, a);
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL rs_addr_ack: got %b expected 0", a);
        end
        for (int i = 0; i < 3; i++) begin
            get_byte(i < 2, d, oe);
            checks++;
            if (d !== exp_b[i]) begin
                errors++;
                $display("FAIL rs_byte%0d: got %h expected %h", i, d, exp_b[i]);
            end
        end
        checks++;
        if (n_idle !== i0) begin
            errors++;
            $display("FAIL rs_busy_gap: got %0d idle cycles expected 0", n_idle - i0);
        end
        i2c_stop;
        checks++;
        if (cmd !== 8'h00 || n_vld - v0 !== 1) begin
            errors++;
            $display("FAIL rs_cmd: got %h/%0d expected 00/1", cmd, n_vld - v0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rs_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_over_read;
        logic a, oe;
        logic [7:0] d;
        logic [7:0] exp_b [5];
        exp_b = '{8'hDE, 8'hAD, 8'h01, 8'hFF, 8'hFF};
        tx_data = 24'hDE_AD_01;
        i2c_start;
        put_byte(8'hED, a);
        for (int i = 0; i < 5; i++) begin
            get_byte(i < 4, d, oe);
            checks++;
            if (d !== exp_b[i]) begin
                errors++;
                $display("FAIL or_byte%0d: got %h expected %h", i, d, exp_b[i]);
            end
        end
        i2c_stop;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL or_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_tx;
        logic a;
        int s0;
        i2c_start;
        put_byte(8'hEC, a);
        put_byte(8'h77, a);
        i2c_stop;
        checks++;
        if (cmd !== 8'h77) begin
            errors++;
            $display("FAIL rm_pre_cmd: got %h expected 77", cmd);
        end
        tx_data = 24'h00_00_00;
        i2c_start;
        put_byte(8'hED, a);
        wt(6);
        checks++;
        if (sda !== 1'b0) begin
            errors++;
            $display("FAIL rm_driving: got %b expected 0", sda);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sda !== 1'b1) begin
            errors++;
            $display("FAIL rm_release: got %b expected 1", sda);
        end
        checks++;
        if (cmd !== 8'h00 || busy !== 1'b0 || cmd_vld !== 1'b0) begin
            errors++;
            $display("FAIL rm_outputs: got %h/%b/%b expected 00/0/0", cmd, busy, cmd_vld);
        end
        wt(3);
        rst_n = 1'b1;
        s0 = n_slow;
        put_bit(1'b1);
        put_bit(1'b1);
        i2c_stop;
        checks++;
        if (n_slow !== s0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_ignore: got %0d low/%b busy expected 0/0", n_slow - s0, busy);
        end
        i2c_start;
        put_byte(8'hEC, a);
        put_byte(8'h3C, a);
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL rm_post_ack: got %b expected 0", a);
        end
        i2c_stop;
        checks++;
        if (cmd !== 8'h3C) begin
            errors++;
            $display("FAIL rm_post_cmd: got %h expected 3C", cmd);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_wrong_addr;
        test_repeated_start;
        test_over_read;
        test_reset_mid_tx;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
